// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_stage_pkg;

  typedef logic [31:0] word;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_t;

  localparam word INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    word pc;
    word instr;
  } fetch_entry_t;

  function automatic word word_align(input word addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry show-ahead FIFO of fetched instructions; entry0 is always the head.
module fetch_queue
  import fetch_stage_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t entry0_r;
  fetch_entry_t entry1_r;
  logic [1:0]   count_r;

  // Shift-register storage; flush dominates push.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r  <= 2'd0;
      entry0_r <= '0;
      entry1_r <= '0;
    end else if (flush) begin
      count_r <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_r == 2'd0) begin
            entry0_r <= push_data;
          end else begin
            entry1_r <= push_data;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          if (count_r != 2'd0) begin
            entry0_r <= entry1_r;
            count_r  <= count_r - 2'd1;
          end
        end
        2'b11: begin
          if (count_r == 2'd2) begin
            entry0_r <= entry1_r;
            entry1_r <= push_data;
          end else begin
            entry0_r <= push_data;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign head  = entry0_r;
  assign count = count_r;

endmodule

// File: rtl/fetch_stage_checker.sv
// Simulation properties for the fetch front end.
module fetch_stage_checker
  import fetch_stage_pkg::*;
(
  input logic         clock,
  input logic         reset,
  input fetch_state_t state,
  input logic         imem_resp_valid,
  input logic [1:0]   count
);

  a_no_resp_in_idle: assert property (@(posedge clock) disable iff (reset)
    !((state == FETCH_IDLE) && imem_resp_valid));

  a_count_bound: assert property (@(posedge clock) disable iff (reset)
    count <= 2'd2);

endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: one outstanding word read, 2-entry instruction queue, redirect flush.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter word         RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        decode_ready,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        inst_valid
);

  fetch_state_t state_r;
  word          fetch_pc_r;
  word          req_pc_r;
  logic [1:0]   count_s;
  fetch_entry_t head_s;
  fetch_entry_t push_data_s;
  logic         push_s;
  logic         pop_s;

  // Request issue, queue control and decode-facing outputs.
  always_comb begin
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    instruction    = INSTR_NOP;
    pc             = 32'h0000_0000;
    pop_s          = 1'b0;
    push_s         = 1'b0;
    if ((state_r == FETCH_IDLE) && ({30'd0, count_s} < QUEUE_DEPTH) && !redirect && !reset) begin
      imem_req_valid = 1'b1;
    end else begin
      imem_req_valid = 1'b0;
    end
    if (count_s != 2'd0) begin
      inst_valid  = 1'b1;
      instruction = head_s.instr;
      pc          = head_s.pc;
    end else begin
      inst_valid  = 1'b0;
      instruction = INSTR_NOP;
      pc          = 32'h0000_0000;
    end
    pop_s  = decode_ready && inst_valid && !redirect;
    push_s = (state_r == FETCH_WAIT) && imem_resp_valid && !redirect && !reset;
  end

  assign imem_req_addr = fetch_pc_r;
  assign push_data_s   = '{pc: req_pc_r, instr: imem_resp_data};

  // Fetch state machine; a redirect turns an in-flight read into one to discard.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= FETCH_IDLE;
      fetch_pc_r <= RESET_PC;
      req_pc_r   <= 32'h0000_0000;
    end else if (redirect) begin
      fetch_pc_r <= word_align(redirect_pc);
      case (state_r)
        FETCH_WAIT, FETCH_DROP: state_r <= imem_resp_valid ? FETCH_IDLE : FETCH_DROP;
        default:                state_r <= FETCH_IDLE;
      endcase
    end else begin
      case (state_r)
        FETCH_IDLE: begin
          if (imem_req_valid && imem_req_ready) begin
            state_r    <= FETCH_WAIT;
            req_pc_r   <= fetch_pc_r;
            fetch_pc_r <= fetch_pc_r + 32'd4;
          end
        end
        FETCH_WAIT, FETCH_DROP: begin
          if (imem_resp_valid) begin
            state_r <= FETCH_IDLE;
          end
        end
        default: state_r <= FETCH_IDLE;
      endcase
    end
  end

  fetch_queue u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .flush     (redirect),
    .head      (head_s),
    .count     (count_s)
  );

  fetch_stage_checker u_checker (
    .clock           (clock),
    .reset           (reset),
    .state           (state_r),
    .imem_resp_valid (imem_resp_valid),
    .count           (count_s)
  );

endmodule
